// File: rtl/corelet_pkg.sv
// Shared types and constants for the corelet per-kij sequencer.
package corelet_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_W_RD,
    S_W_TAIL,
    S_K_LOAD,
    S_K_FLUSH,
    S_X_RD,
    S_X_TAIL,
    S_EXEC,
    S_DRAIN
  } state_t;

  // Bit positions on the corelet inst bus
  localparam int KLOAD = 0;
  localparam int EXEC  = 1;
  localparam int L0WR  = 2;
  localparam int L0RD  = 3;
  localparam int OFRD  = 6;

  localparam int DEF_ROW     = 8;
  localparam int DEF_COL     = 8;
  localparam int DEF_LEN_NIJ = 36;
  localparam int DEF_LEN_KIJ = 9;
  localparam int DEF_XA_BW   = 11;
  localparam int DEF_PA_BW   = 11;
  localparam int DEF_W_BASE  = 1024;
  localparam int DEF_X_BASE  = 0;

  // Wide enough for the longest phase (len_nij)
  localparam int CNT_W = 8;

endpackage

// File: rtl/corelet_ctrl_pass_counter.sv
// Up-counter with synchronous clear-to-zero and terminal-count flag against a run-time limit.
module pass_counter #(
  parameter int w = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [w-1:0] last,
  output logic [w-1:0] cnt,
  output logic         tc
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + w'(1);
    end
  end

  assign tc = (cnt == last);

endmodule

// File: rtl/corelet_ctrl.sv
// Per-kij sequencer: weight fetch, kernel load, activation fetch/execute, OFIFO drain to psum SRAM.
module corelet_ctrl
  import corelet_pkg::*;
#(
  parameter int row     = DEF_ROW,
  parameter int col     = DEF_COL,
  parameter int len_nij = DEF_LEN_NIJ,
  parameter int len_kij = DEF_LEN_KIJ,
  parameter int xa_bw   = DEF_XA_BW,
  parameter int pa_bw   = DEF_PA_BW,
  parameter int w_base  = DEF_W_BASE,
  parameter int x_base  = DEF_X_BASE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       kij,
  input  logic             ofifo_valid,
  output logic [7:0]       inst,
  output logic             xmem_cen,
  output logic [xa_bw-1:0] xmem_addr,
  output logic             pmem_cen,
  output logic             pmem_wen,
  output logic [pa_bw-1:0] pmem_addr,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_t           state;
  logic [3:0]       kij_reg;
  logic [CNT_W-1:0] pcnt;
  logic [CNT_W-1:0] dcnt;
  logic [CNT_W-1:0] phase_last;
  logic             phase_tc;
  logic             drain_tc;
  logic             advance;
  logic             phase_load;
  logic             drain_load;
  logic             drain_en;
  logic [xa_bw-1:0] w_addr;
  logic [xa_bw-1:0] x_addr;
  logic [pa_bw-1:0] p_addr;

  always_comb begin
    phase_last = '0;
    case (state)
      S_W_RD, S_K_FLUSH: phase_last = CNT_W'(row - 1);
      S_K_LOAD:          phase_last = CNT_W'(col - 1);
      S_X_RD, S_EXEC:    phase_last = CNT_W'(len_nij - 1);
      default:           phase_last = '0;
    endcase
  end

  // Phase counter restarts on every state change; single-cycle states see tc at cnt 0
  assign advance    = (state != S_IDLE) && (state != S_DRAIN) && phase_tc;
  assign phase_load = advance || (state == S_IDLE);
  assign drain_load = (state != S_DRAIN);
  assign drain_en   = (state == S_DRAIN) && ofifo_valid;

  assign w_addr = xa_bw'(w_base + int'(kij_reg) * col + int'(pcnt));
  assign x_addr = xa_bw'(x_base + int'(pcnt));
  assign p_addr = pa_bw'(int'(kij_reg) * len_nij + int'(dcnt));

  pass_counter #(.w(CNT_W)) u_phase_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (phase_load),
    .en    (!phase_load),
    .last  (phase_last),
    .cnt   (pcnt),
    .tc    (phase_tc)
  );

  pass_counter #(.w(CNT_W)) u_drain_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (drain_load),
    .en    (drain_en),
    .last  (CNT_W'(len_nij - 1)),
    .cnt   (dcnt),
    .tc    (drain_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      kij_reg   <= '0;
      inst      <= '0;
      xmem_cen  <= 1'b1;
      xmem_addr <= '0;
      pmem_cen  <= 1'b1;
      pmem_wen  <= 1'b1;
      pmem_addr <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      inst       <= '0;
      // L0 captures the xmem word one cycle after the read is issued
      inst[L0WR] <= ~xmem_cen;
      xmem_cen   <= 1'b1;
      pmem_cen   <= 1'b1;
      pmem_wen   <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
      busy       <= (state != S_IDLE);
      case (state)
        S_IDLE: begin
          if (start) begin
            if (int'(kij) < len_kij) begin
              kij_reg <= kij;
              state   <= S_W_RD;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_W_RD: begin
          xmem_cen  <= 1'b0;
          xmem_addr <= w_addr;
          if (phase_tc) state <= S_W_TAIL;
        end
        S_W_TAIL: state <= S_K_LOAD;
        S_K_LOAD: begin
          inst[L0RD]  <= 1'b1;
          inst[KLOAD] <= 1'b1;
          if (phase_tc) state <= S_K_FLUSH;
        end
        S_K_FLUSH: begin
          if (phase_tc) state <= S_X_RD;
        end
        S_X_RD: begin
          xmem_cen  <= 1'b0;
          xmem_addr <= x_addr;
          if (phase_tc) state <= S_X_TAIL;
        end
        S_X_TAIL: state <= S_EXEC;
        S_EXEC: begin
          inst[L0RD] <= 1'b1;
          inst[EXEC] <= 1'b1;
          if (phase_tc) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (ofifo_valid) begin
            inst[OFRD] <= 1'b1;
            pmem_cen   <= 1'b0;
            pmem_wen   <= 1'b0;
            pmem_addr  <= p_addr;
            if (drain_tc) begin
              done  <= 1'b1;
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
